// File: rtl/uart_tx_dev.sv
// Purpose : memory-mapped 8N1 UART transmitter with TX FIFO, baud divisor and done interrupt.
// Latency : tx falls 1 cycle after the DATA write edge when idle; frame = 10*DIV (11*DIV with parity).
// Backpr. : no stall to the bus; a push into a full FIFO is dropped and sets sticky ovf.
//
// Ports: clk, reset (async active-high), Addr[29:0] (word address, [1:0] decoded),
//        WE (write strobe), Din[31:0], Dout[31:0] (combinational read), IRQ (irq_en && done),
//        tx (serial line, idle high).
// Registers: 0 DATA (W push), 1 STATUS {ovf,done,empty,full,busy} (any W clears ovf/done),
//            2 CTRL {odd,irq_en,tx_en}, 3 DIV [15:0] (0 stored as 1).
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit and CTRL bit2 (odd select).
module uart_tx_dev #(
    parameter int DIVISOR    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic          tx_q, tx_d;
    logic [15:0]   div_q, div_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic sel_data, sel_status, sel_ctrl, sel_div;
    logic full, empty, busy, push, pop, ovf_set, done_set, start_ok;
    logic tx_en, odd_sel, par_bit;
    logic [15:0] div_m1;

    // Address bits above [1:0] and the upper data half are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{Addr[29:2], Din[31:16]};

    assign sel_data   = WE && (Addr[1:0] == 2'd0);
    assign sel_status = WE && (Addr[1:0] == 2'd1);
    assign sel_ctrl   = WE && (Addr[1:0] == 2'd2);
    assign sel_div    = WE && (Addr[1:0] == 2'd3);

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign busy     = (state_q != S_IDLE);
    assign tx_en    = ctrl_q[0];
    assign odd_sel  = ctrl_q[2];
    assign start_ok = tx_en && !empty;
    assign div_m1   = div_q - 16'd1;
    assign par_bit  = (^byte_q) ^ odd_sel;

    // A push into a full FIFO still lands if the serialiser pops in the same cycle.
    assign push    = sel_data && (!full || pop);
    assign ovf_set = sel_data && full && !pop;

    // Serialiser next state. tx is registered from the next-state decision so the
    // line changes exactly on bit boundaries and is glitch-free.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        tx_d     = tx_q;
        pop      = 1'b0;
        done_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (start_ok) begin
                    state_d = S_START;
                    pop     = 1'b1;
                    byte_d  = mem_q[rd_ptr_q];
                    cnt_d   = div_m1;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    cnt_d   = div_m1;
                    tx_d    = byte_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = div_m1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_bit;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = byte_q[bit_d];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_STOP;
                    cnt_d   = div_m1;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == 16'd0) begin
                    if (start_ok) begin
                        // Back-to-back: next start bit follows the stop bit directly.
                        state_d = S_START;
                        pop     = 1'b1;
                        byte_d  = mem_q[rd_ptr_q];
                        cnt_d   = div_m1;
                        tx_d    = 1'b0;
                    end else begin
                        state_d  = S_IDLE;
                        done_set = 1'b1;
                        tx_d     = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // FIFO and register file next state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = Din[7:0];
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        div_d = div_q;
        if (sel_div) begin
            div_d = (Din[15:0] == 16'd0) ? 16'd1 : Din[15:0];
        end

        ctrl_d = ctrl_q;
        if (sel_ctrl) begin
`ifdef UART_TX_PARITY_EN
            ctrl_d = Din[2:0];
`else
            ctrl_d = {1'b0, Din[1:0]};
`endif
        end

        // Set has priority over the STATUS-write clear.
        ovf_d  = ovf_q;
        done_d = done_q;
        if (sel_status) begin
            ovf_d  = 1'b0;
            done_d = 1'b0;
        end
        if (ovf_set)  ovf_d  = 1'b1;
        if (done_set) done_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            tx_q     <= 1'b1;
            div_q    <= 16'(DIVISOR);
            ctrl_q   <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            tx_q     <= tx_d;
            div_q    <= div_d;
            ctrl_q   <= ctrl_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr[1:0])
            2'd1:    Dout = {27'd0, ovf_q, done_q, empty, full, busy};
            2'd2:    Dout = {29'd0, ctrl_q};
            2'd3:    Dout = {16'd0, div_q};
            default: Dout = 32'd0;
        endcase
    end

    assign IRQ = ctrl_q[1] & done_q;
    assign tx  = tx_q;

endmodule
